// File: rtl/parking_gate_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking gate controller:
//   - FSM state encoding (IDLE / gate open for entry / gate open for exit)
//   - gate direction constants driven on gate_dir
//   - default sizing constants used by the system-level top
// No ports (package).
// -----------------------------------------------------------------------------
package parking_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_EXIT  = 2'd2
  } gate_state_e;

  localparam logic DIR_ENTRY = 1'b1;
  localparam logic DIR_EXIT  = 1'b0;

  localparam int DEF_CAPACITY    = 8;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_GATE_CYCLES = 20;

endpackage : parking_pkg

// File: rtl/parking_gate_ctrl_rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Converts a debounced button level into a single-cycle press pulse.
// The history register resets to 1 so a button already held when reset is
// released does not produce a press until it has been released once.
// Ports:
//   clk_i    - clock, history updates on rising edge
//   rst_ni   - asynchronous active-low reset
//   level_i  - debounced button level
//   press_o  - high for the one cycle in which level_i first reads high
// -----------------------------------------------------------------------------
module rise_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic press_o
);

  logic prev_q;

  // History of the level, sampled every cycle regardless of controller state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level_i;
    end
  end

  assign press_o = level_i & ~prev_q;

endmodule : rise_detect

// File: rtl/parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// parking_gate_ctrl
// Tracks parking lot occupancy against a fixed capacity and drives a barrier
// gate open for GATE_CYCLES cycles for every admitted entry or exit.
// Entry is refused (deny pulse) when full, exit is refused when empty.
// Presses arriving while the gate is open are discarded.
// Ports:
//   clk          - system clock
//   reset        - asynchronous active-low reset
//   entry_btn    - debounced entry button level
//   exit_btn     - debounced exit button level
//   gate_open    - barrier open (registered)
//   gate_dir     - 1 = opened for entry, 0 = opened for exit; 0 while closed
//   occupancy    - cars inside (registered)
//   free_spaces  - CAPACITY - occupancy (registered)
//   full         - occupancy == CAPACITY (registered)
//   empty        - occupancy == 0 (registered)
//   deny         - one-cycle pulse when a press is refused
// -----------------------------------------------------------------------------
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY    = DEF_CAPACITY,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_btn,
  input  logic             exit_btn,
  output logic             gate_open,
  output logic             gate_dir,
  output logic [CNT_W-1:0] occupancy,
  output logic [CNT_W-1:0] free_spaces,
  output logic             full,
  output logic             empty,
  output logic             deny
);

  // Timer only has to hold GATE_CYCLES-1; keep at least one bit.
  localparam int TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] TMR_LD_C = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_Z_C  = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_1_C  = {{(TMR_W-1){1'b0}}, 1'b1};

  logic entry_press_s;
  logic exit_press_s;

  gate_state_e      state_q;
  logic [TMR_W-1:0] timer_q;
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] free_q;
  logic             full_q;
  logic             empty_q;
  logic             deny_q;
  logic             gate_open_q;
  logic             gate_dir_q;

  rise_detect u_entry_rise (
    .clk_i   (clk),
    .rst_ni  (reset),
    .level_i (entry_btn),
    .press_o (entry_press_s)
  );

  rise_detect u_exit_rise (
    .clk_i   (clk),
    .rst_ni  (reset),
    .level_i (exit_btn),
    .press_o (exit_press_s)
  );

  // Gate FSM with inline occupancy counter, open timer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= TMR_Z_C;
      occ_q       <= ZERO_C;
      free_q      <= CAP_C;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      deny_q      <= 1'b0;
      gate_open_q <= 1'b0;
      gate_dir_q  <= 1'b0;
    end else begin
      // deny is a pulse; only the refusal branches below raise it.
      deny_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Exit wins over a simultaneous entry; the entry is simply dropped.
          if (exit_press_s) begin
            if (occ_q != ZERO_C) begin
              state_q     <= ST_EXIT;
              timer_q     <= TMR_LD_C;
              occ_q       <= occ_q - ONE_C;
              free_q      <= free_q + ONE_C;
              full_q      <= 1'b0;
              empty_q     <= (occ_q == ONE_C);
              gate_open_q <= 1'b1;
              gate_dir_q  <= DIR_EXIT;
            end else begin
              deny_q <= 1'b1;
            end
          end else if (entry_press_s) begin
            if (occ_q != CAP_C) begin
              state_q     <= ST_ENTRY;
              timer_q     <= TMR_LD_C;
              occ_q       <= occ_q + ONE_C;
              free_q      <= free_q - ONE_C;
              full_q      <= (occ_q == (CAP_C - ONE_C));
              empty_q     <= 1'b0;
              gate_open_q <= 1'b1;
              gate_dir_q  <= DIR_ENTRY;
            end else begin
              deny_q <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ENTRY, ST_EXIT: begin
          // Presses are ignored here; the timer alone ends the opening.
          if (timer_q == TMR_Z_C) begin
            state_q     <= ST_IDLE;
            gate_open_q <= 1'b0;
            gate_dir_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_1_C;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          timer_q     <= TMR_Z_C;
          gate_open_q <= 1'b0;
          gate_dir_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gate_open   = gate_open_q;
  assign gate_dir    = gate_dir_q;
  assign occupancy   = occ_q;
  assign free_spaces = free_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign deny        = deny_q;

endmodule : parking_gate_ctrl

// File: tb/tb_parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_ctrl
// Self-checking bench for parking_gate_ctrl (CAPACITY=3, GATE_CYCLES=4).
// A behavioural model (car count, remaining open cycles, last levels) predicts
// every output after each clock edge; directed scenarios are followed by a
// randomized phase with occasional asynchronous resets.
// -----------------------------------------------------------------------------
module tb_parking_gate_ctrl;

  localparam int CAP = 3;
  localparam int CW  = 4;
  localparam int GC  = 4;

  logic          clk;
  logic          reset;
  logic          entry_btn;
  logic          exit_btn;
  logic          gate_open;
  logic          gate_dir;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] free_spaces;
  logic          full;
  logic          empty;
  logic          deny;

  int n_checks;
  int n_errors;

  // behavioural model state
  int   m_occ;
  int   m_busy;
  logic m_dir;
  logic m_deny;
  logic m_prev_en;
  logic m_prev_ex;

  parking_gate_ctrl #(
    .CAPACITY    (CAP),
    .CNT_W       (CW),
    .GATE_CYCLES (GC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .entry_btn   (entry_btn),
    .exit_btn    (exit_btn),
    .gate_open   (gate_open),
    .gate_dir    (gate_dir),
    .occupancy   (occupancy),
    .free_spaces (free_spaces),
    .full        (full),
    .empty       (empty),
    .deny        (deny)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ     = 0;
    m_busy    = 0;
    m_dir     = 1'b0;
    m_deny    = 1'b0;
    m_prev_en = 1'b1;
    m_prev_ex = 1'b1;
  endtask

  // One clock edge of the lot's rules, applied to the levels seen at that edge.
  task automatic model_step();
    logic pe;
    logic px;
    pe = entry_btn & ~m_prev_en;
    px = exit_btn & ~m_prev_ex;
    m_prev_en = entry_btn;
    m_prev_ex = exit_btn;
    m_deny = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
    end else if (px) begin
      if (m_occ > 0) begin
        m_occ--;
        m_busy = GC;
        m_dir = 1'b0;
      end else begin
        m_deny = 1'b1;
      end
    end else if (pe) begin
      if (m_occ < CAP) begin
        m_occ++;
        m_busy = GC;
        m_dir = 1'b1;
      end else begin
        m_deny = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check_val({tag, ".open"},  32'(gate_open),   32'(m_busy > 0));
    check_val({tag, ".dir"},   32'(gate_dir),    32'((m_busy > 0) ? m_dir : 1'b0));
    check_val({tag, ".occ"},   32'(occupancy),   32'(m_occ));
    check_val({tag, ".free"},  32'(free_spaces), 32'(CAP - m_occ));
    check_val({tag, ".full"},  32'(full),        32'(m_occ == CAP));
    check_val({tag, ".empty"}, 32'(empty),       32'(m_occ == 0));
    check_val({tag, ".deny"},  32'(deny),        32'(m_deny));
  endtask

  // Drive levels for the next edge, advance model, check 1 time unit later.
  task automatic cycle(input logic en, input logic ex, input string tag);
    entry_btn = en;
    exit_btn  = ex;
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, tag);
  endtask

  initial begin
    int open_cnt;
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    entry_btn = 1'b0;
    exit_btn  = 1'b0;
    model_reset();

    // Reset held: inputs toggle, nothing moves.
    for (int i = 0; i < 4; i++) begin
      entry_btn = i[0];
      exit_btn  = ~i[0];
      @(posedge clk);
      #1;
      check_model("rst_hold");
    end
    exit_btn  = 1'b0;
    entry_btn = 1'b1;
    reset     = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "rst_rel");
    check_val("rst_rel_occ", 32'(occupancy), 32'd0);
    check_val("rst_rel_gate", 32'(gate_open), 32'd0);

    // Single entry with a long hold: exactly one event, GC open cycles.
    cycle(1'b0, 1'b0, "pre1");
    open_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, "ent1");
      if (gate_open) open_cnt++;
      if (gate_open) check_val("ent1_dir", 32'(gate_dir), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, "ent1_idle");
      if (gate_open) open_cnt++;
    end
    check_val("ent1_open_cycles", 32'(open_cnt), 32'(GC));
    check_val("ent1_occ", 32'(occupancy), 32'd1);
    check_val("ent1_free", 32'(free_spaces), 32'd2);

    // Fill to capacity, then a refused entry.
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 1'b0, "fill");
      idle(6, "fill_idle");
    end
    check_val("fill_full", 32'(full), 32'd1);
    cycle(1'b1, 1'b0, "deny_full");
    check_val("deny_full_pulse", 32'(deny), 32'd1);
    check_val("deny_full_gate", 32'(gate_open), 32'd0);
    cycle(1'b0, 1'b0, "deny_full_end");
    check_val("deny_full_drop", 32'(deny), 32'd0);
    check_val("deny_full_occ", 32'(occupancy), 32'd3);

    // Drain, then exit at empty is refused.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, "drain");
      check_val("drain_dir", 32'(gate_dir), 32'd0);
      idle(6, "drain_idle");
    end
    check_val("drain_empty", 32'(empty), 32'd1);
    cycle(1'b0, 1'b1, "deny_empty");
    check_val("deny_empty_pulse", 32'(deny), 32'd1);
    idle(2, "deny_empty_idle");

    // Reach occupancy 2, then simultaneous presses: exit wins, no deny.
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 1'b0, "sim_fill");
      idle(6, "sim_fill_idle");
    end
    cycle(1'b1, 1'b1, "sim");
    check_val("sim_occ", 32'(occupancy), 32'd1);
    check_val("sim_dir", 32'(gate_dir), 32'd0);
    check_val("sim_deny", 32'(deny), 32'd0);
    cycle(1'b0, 1'b0, "sim_gap");
    cycle(1'b1, 1'b0, "sim_ignored");
    idle(6, "sim_idle");
    check_val("sim_after_occ", 32'(occupancy), 32'd1);

    // Reset during the second open cycle at occupancy 2.
    cycle(1'b1, 1'b0, "mid_ent");
    cycle(1'b0, 1'b0, "mid_open2");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_val("mid_rst_gate", 32'(gate_open), 32'd0);
    check_val("mid_rst_occ", 32'(occupancy), 32'd0);
    check_model("mid_rst");
    reset = 1'b1;
    idle(2, "mid_rst_idle");

    // Randomized levels with sporadic asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      logic en;
      logic ex;
      en = entry_btn;
      ex = exit_btn;
      if ($urandom_range(0, 2) == 0) en = ~en;
      if ($urandom_range(0, 3) == 0) ex = ~ex;
      cycle(en, ex, "rnd");
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_model("rnd_rst");
        reset = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_parking_gate_ctrl
